// File: rtl/page_layout.sv
// -----------------------------------------------------------------------------
// page_layout
//
// Maps character-local pen points (x, y, z) onto a page. Each accepted point
// is scaled down by the per-line character count n using three serial
// restoring dividers that share one control counter, then offset by the
// current character cursor. A separate cursor FSM advances the character cell
// on an asynchronous "adv" request. When the page fills, it waits for a
// "contin" request.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   n                     characters per line (divisor)
//   pt_valid / pt_ready   input point handshake
//   x, y, z, plus         character-local point and deep-stroke mode
//   out_valid / out_ready output point handshake
//   mx, my, mz            page-global point, held while out_valid is high
//   adv, just, contin     asynchronous advance request, advance suppress,
//                         page-continue request
//   full, busy, err_div   page full, cursor update running, last point had n=0
// -----------------------------------------------------------------------------
module page_layout #(
  parameter int CW        = 10,
  parameter int PW        = 11,
  parameter int NW        = 4,
  parameter int X_EDGE    = 2001,
  parameter int Y_EDGE    = 1501,
  parameter int CELL_FULL = 1000,
  parameter int Z_THR     = 200,
  parameter int Z_PLUS    = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NW-1:0] n,
  input  logic          pt_valid,
  output logic          pt_ready,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-2:0] z,
  input  logic          plus,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] mx,
  output logic [PW-1:0] my,
  output logic [CW-2:0] mz,
  input  logic          adv,
  input  logic          just,
  input  logic          contin,
  output logic          full,
  output logic          busy,
  output logic          err_div
);

  localparam int PCW = $clog2(CW + 1);  // point divider counts 0..CW
  localparam int CCW = $clog2(PW);      // size divider counts 0..PW-1

  localparam logic [CW-1:0] ZTHR_C   = CW'(Z_THR);
  localparam logic [CW-1:0] ZPLUS_C  = CW'(Z_PLUS);
  localparam logic [PW-1:0] CELL_C   = PW'(CELL_FULL);
  localparam logic [PW+1:0] XEDGE_C  = (PW+2)'(X_EDGE);
  localparam logic [PW+1:0] YEDGE_C  = (PW+2)'(Y_EDGE);

  typedef enum logic [1:0] {P_IDLE, P_DIV, P_OUT} p_state_t;
  typedef enum logic [2:0] {C_IDLE, C_SIZE, C_MAX, C_STEP, C_WAIT} c_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  p_state_t        p_state_q, p_state_d;
  c_state_t        c_state_q, c_state_d;

  logic [PCW-1:0]  p_cnt_q, p_cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [CW-2:0]   z_q, z_d;
  logic            dz_nz_q, dz_nz_d;
  logic [CW-1:0]   dvd_q [3];
  logic [CW-1:0]   dvd_d [3];
  logic [NW-1:0]   rem_q [3];
  logic [NW-1:0]   rem_d [3];
  logic [CW-1:0]   quo_q [3];
  logic [CW-1:0]   quo_d [3];
  logic [PW-1:0]   mx_q, mx_d, my_q, my_d;
  logic [CW-2:0]   mz_q, mz_d;
  logic            err_q, err_d;
  logic            init_q;

  logic            adv_s1_q, adv_s2_q, adv_s3_q;
  logic            cont_s1_q, cont_s2_q, cont_s3_q;

  logic            pend_q, pend_d;
  logic            full_q, full_d;
  logic [PW-1:0]   x_cur_q, x_cur_d;
  logic [PW-1:0]   y_cur_q, y_cur_d;
  logic [PW-1:0]   y_max_q, y_max_d;
  logic [PW-1:0]   size_q, size_d;
  logic [NW-1:0]   c_n_q, c_n_d;
  logic [PW-1:0]   c_dvd_q, c_dvd_d;
  logic [NW-1:0]   c_rem_q, c_rem_d;
  logic [PW-1:0]   c_quo_q, c_quo_d;
  logic [CCW-1:0]  c_cnt_q, c_cnt_d;

  // ---------------------------------------------------------------------------
  // Point divider lanes: 0 = x, 1 = y, 2 = dz. One restoring step each; the
  // remainder always stays below n, so NW bits hold it between steps.
  // ---------------------------------------------------------------------------
  logic [NW:0]     trial    [3];
  logic [NW-1:0]   step_rem [3];
  logic            step_bit [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    assign trial[gi]    = {rem_q[gi], dvd_q[gi][CW-1]};
    assign step_bit[gi] = (trial[gi] >= {1'b0, n_q});
    assign step_rem[gi] = step_bit[gi] ? NW'(trial[gi] - {1'b0, n_q})
                                       : trial[gi][NW-1:0];
  end

  // Size divider step.
  logic [NW:0]     c_trial;
  logic            c_bit;
  logic [NW-1:0]   c_step_rem;

  assign c_trial    = {c_rem_q, c_dvd_q[PW-1]};
  assign c_bit      = (c_trial >= {1'b0, c_n_q});
  assign c_step_rem = c_bit ? NW'(c_trial - {1'b0, c_n_q}) : c_trial[NW-1:0];

  // Synchronised rising edges.
  logic adv_ev, cont_ev;
  assign adv_ev  = adv_s2_q & ~adv_s3_q;
  assign cont_ev = cont_s2_q & ~cont_s3_q;

  // pt_ready is held off while an advance is pending. That keeps a point
  // accept and a cursor start from landing on the same edge, so the cursor
  // cannot move underneath a point that is in flight.
  logic accept;
  assign pt_ready  = init_q & (p_state_q == P_IDLE) & (c_state_q == C_IDLE) & ~pend_q;
  assign accept    = pt_valid & pt_ready;
  assign out_valid = (p_state_q == P_OUT);
  assign busy      = (c_state_q != C_IDLE);
  assign full      = full_q;
  assign err_div   = err_q;
  assign mx        = mx_q;
  assign my        = my_q;
  assign mz        = mz_q;

  // ---------------------------------------------------------------------------
  // Point FSM
  // ---------------------------------------------------------------------------
  logic [CW-1:0] z_ext, dz_in;
  logic [CW-1:0] quo_x, quo_y, quo_z, mz_sum;

  always_comb begin
    z_ext = {1'b0, z};
    dz_in = '0;
    if (z_ext > ZTHR_C) begin
      dz_in = plus ? (z_ext - ZTHR_C + ZPLUS_C) : (z_ext - ZTHR_C);
    end

    // With n=0 the restoring steps would produce all ones, so the quotients
    // are forced to zero here.
    quo_x  = (n_q == '0) ? '0 : quo_q[0];
    quo_y  = (n_q == '0) ? '0 : quo_q[1];
    quo_z  = (n_q == '0) ? '0 : quo_q[2];
    mz_sum = quo_z + ZTHR_C;

    p_state_d = p_state_q;
    p_cnt_d   = p_cnt_q;
    n_d       = n_q;
    z_d       = z_q;
    dz_nz_d   = dz_nz_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    mx_d      = mx_q;
    my_d      = my_q;
    mz_d      = mz_q;
    err_d     = err_q;

    case (p_state_q)
      P_IDLE: begin
        if (accept) begin
          n_d      = n;
          z_d      = z;
          dz_nz_d  = (dz_in != '0);
          dvd_d[0] = x;
          dvd_d[1] = y;
          dvd_d[2] = dz_in;
          for (int i = 0; i < 3; i++) begin
            rem_d[i] = '0;
            quo_d[i] = '0;
          end
          p_cnt_d   = '0;
          err_d     = (n == '0);
          p_state_d = P_DIV;
        end
      end
      P_DIV: begin
        if (p_cnt_q != PCW'(CW)) begin
          for (int i = 0; i < 3; i++) begin
            rem_d[i] = step_rem[i];
            quo_d[i] = {quo_q[i][CW-2:0], step_bit[i]};
            dvd_d[i] = dvd_q[i] << 1;
          end
          p_cnt_d = p_cnt_q + 1'b1;
        end else begin
          // Quotients are complete; register the page point and present it.
          mx_d      = x_cur_q + PW'(quo_x);
          my_d      = y_cur_q + PW'(quo_y);
          mz_d      = dz_nz_q ? mz_sum[CW-2:0] : z_q;
          p_state_d = P_OUT;
        end
      end
      P_OUT: begin
        if (out_ready) begin
          p_state_d = P_IDLE;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cursor FSM
  // ---------------------------------------------------------------------------
  logic [PW+1:0] x_need, y_need;

  always_comb begin
    x_need = {2'b00, x_cur_q} + {1'b0, size_q, 1'b0};
    y_need = {2'b00, y_cur_q} + {1'b0, size_q, 1'b0};

    c_state_d = c_state_q;
    pend_d    = pend_q;
    full_d    = full_q;
    x_cur_d   = x_cur_q;
    y_cur_d   = y_cur_q;
    y_max_d   = y_max_q;
    size_d    = size_q;
    c_n_d     = c_n_q;
    c_dvd_d   = c_dvd_q;
    c_rem_d   = c_rem_q;
    c_quo_d   = c_quo_q;
    c_cnt_d   = c_cnt_q;

    // Only one advance may be queued, and only while the cursor is idle.
    if (adv_ev && !just && !pend_q && (c_state_q == C_IDLE)) begin
      pend_d = 1'b1;
    end

    case (c_state_q)
      C_IDLE: begin
        if (pend_q && (p_state_q == P_IDLE)) begin
          pend_d    = 1'b0;
          c_n_d     = n;
          // Adding n/2 before dividing rounds the cell size to nearest.
          c_dvd_d   = CELL_C + PW'(n >> 1);
          c_rem_d   = '0;
          c_quo_d   = '0;
          c_cnt_d   = '0;
          c_state_d = C_SIZE;
        end
      end
      C_SIZE: begin
        c_rem_d = c_step_rem;
        c_quo_d = {c_quo_q[PW-2:0], c_bit};
        c_dvd_d = c_dvd_q << 1;
        c_cnt_d = c_cnt_q + 1'b1;
        if (c_cnt_q == CCW'(PW - 1)) begin
          size_d    = (c_n_q == '0) ? '0 : {c_quo_q[PW-2:0], c_bit};
          c_state_d = C_MAX;
        end
      end
      C_MAX: begin
        if (size_q > y_max_q) begin
          y_max_d = size_q;
        end
        c_state_d = C_STEP;
      end
      C_STEP: begin
        // Step along the line while two cells still fit; otherwise start a
        // new line; if no line fits either, the page is full.
        if (x_need <= XEDGE_C) begin
          x_cur_d   = x_cur_q + size_q;
          c_state_d = C_IDLE;
        end else if (y_need <= YEDGE_C) begin
          x_cur_d   = '0;
          y_cur_d   = y_cur_q + y_max_q;
          y_max_d   = '0;
          c_state_d = C_IDLE;
        end else begin
          x_cur_d   = '0;
          y_cur_d   = '0;
          y_max_d   = '0;
          full_d    = 1'b1;
          c_state_d = C_WAIT;
        end
      end
      C_WAIT: begin
        if (cont_ev) begin
          full_d    = 1'b0;
          c_state_d = C_IDLE;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q <= P_IDLE;
      c_state_q <= C_IDLE;
      p_cnt_q   <= '0;
      n_q       <= '0;
      z_q       <= '0;
      dz_nz_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        dvd_q[i] <= '0;
        rem_q[i] <= '0;
        quo_q[i] <= '0;
      end
      mx_q      <= '0;
      my_q      <= '0;
      mz_q      <= '0;
      err_q     <= 1'b0;
      init_q    <= 1'b0;
      adv_s1_q  <= 1'b0;
      adv_s2_q  <= 1'b0;
      adv_s3_q  <= 1'b0;
      cont_s1_q <= 1'b0;
      cont_s2_q <= 1'b0;
      cont_s3_q <= 1'b0;
      pend_q    <= 1'b0;
      full_q    <= 1'b0;
      x_cur_q   <= '0;
      y_cur_q   <= '0;
      y_max_q   <= '0;
      size_q    <= '0;
      c_n_q     <= '0;
      c_dvd_q   <= '0;
      c_rem_q   <= '0;
      c_quo_q   <= '0;
      c_cnt_q   <= '0;
    end else begin
      p_state_q <= p_state_d;
      c_state_q <= c_state_d;
      p_cnt_q   <= p_cnt_d;
      n_q       <= n_d;
      z_q       <= z_d;
      dz_nz_q   <= dz_nz_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      mz_q      <= mz_d;
      err_q     <= err_d;
      // Keeps pt_ready low until the first edge after reset release.
      init_q    <= 1'b1;
      adv_s1_q  <= adv;
      adv_s2_q  <= adv_s1_q;
      adv_s3_q  <= adv_s2_q;
      cont_s1_q <= contin;
      cont_s2_q <= cont_s1_q;
      cont_s3_q <= cont_s2_q;
      pend_q    <= pend_d;
      full_q    <= full_d;
      x_cur_q   <= x_cur_d;
      y_cur_q   <= y_cur_d;
      y_max_q   <= y_max_d;
      size_q    <= size_d;
      c_n_q     <= c_n_d;
      c_dvd_q   <= c_dvd_d;
      c_rem_q   <= c_rem_d;
      c_quo_q   <= c_quo_d;
      c_cnt_q   <= c_cnt_d;
    end
  end

endmodule

// File: tb/tb_page_layout.sv
// -----------------------------------------------------------------------------
// tb_page_layout
//
// Self-checking bench for page_layout. A behavioural model keeps the page
// cursor as plain integers and derives every expected page point from the
// arithmetic rules (integer division, thresholds, edge tests). Directed
// scenarios are followed by a randomized mix of points, advances and
// page-continue requests.
// -----------------------------------------------------------------------------
module tb_page_layout;

  localparam int CW = 10;
  localparam int PW = 11;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NW-1:0] n = '0;
  logic          pt_valid = 1'b0;
  logic          pt_ready;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic [CW-2:0] z = '0;
  logic          plus = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] mx, my;
  logic [CW-2:0] mz;
  logic          adv = 1'b0;
  logic          just = 1'b0;
  logic          contin = 1'b0;
  logic          full, busy, err_div;

  always #5 clk = ~clk;

  page_layout dut (
    .clk(clk), .rst_n(rst_n), .n(n),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .x(x), .y(y), .z(z), .plus(plus),
    .out_valid(out_valid), .out_ready(out_ready),
    .mx(mx), .my(my), .mz(mz),
    .adv(adv), .just(just), .contin(contin),
    .full(full), .busy(busy), .err_div(err_div)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference cursor.
  int m_xcur = 0;
  int m_ycur = 0;
  int m_ymax = 0;
  bit m_full = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cell_size(input int nn);
    return (nn == 0) ? 0 : (1000 + nn / 2) / nn;
  endfunction

  function automatic void model_adv(input int nn);
    int s;
    s = cell_size(nn);
    if (s > m_ymax) m_ymax = s;
    if (m_xcur + 2 * s <= 2001) begin
      m_xcur = m_xcur + s;
    end else if (m_ycur + 2 * s <= 1501) begin
      m_xcur = 0;
      m_ycur = (m_ycur + m_ymax) % 2048;
      m_ymax = 0;
    end else begin
      m_xcur = 0;
      m_ycur = 0;
      m_ymax = 0;
      m_full = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_xcur = 0;
    m_ycur = 0;
    m_ymax = 0;
    m_full = 1'b0;
  endfunction

  // One point through the full handshake, with `stall` cycles of out_ready=0.
  task automatic send_point(input int nn, input int xx, input int yy, input int zz,
                            input int pl, input int stall);
    int dz, qx, qy, qz, emx, emy, emz, k;
    dz  = (zz > 200) ? ((pl != 0) ? zz - 200 + 30 : zz - 200) : 0;
    qx  = (nn == 0) ? 0 : xx / nn;
    qy  = (nn == 0) ? 0 : yy / nn;
    qz  = (nn == 0) ? 0 : dz / nn;
    emx = (m_xcur + qx) % 2048;
    emy = (m_ycur + qy) % 2048;
    emz = (dz > 0) ? (qz + 200) % 512 : zz;

    n = NW'(nn); x = CW'(xx); y = CW'(yy); z = (CW-1)'(zz); plus = pl[0];
    out_ready = 1'b0;
    pt_valid  = 1'b1;
    k = 0;
    while (!pt_ready && k < 100) begin
      tick();
      k++;
    end
    check("pt_ready_wait", int'(pt_ready), 1);
    tick();
    pt_valid = 1'b0;
    // Scramble inputs: the design must work from its latched copies.
    x = CW'($urandom); y = CW'($urandom); z = (CW-1)'($urandom); plus = ~plus;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    check("latency", k, 11);
    check("mx", int'(mx), emx);
    check("my", int'(my), emy);
    check("mz", int'(mz), emz);
    check("err_div", int'(err_div), (nn == 0) ? 1 : 0);
    if (stall > 0) begin
      repeat (stall) tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_mx", int'(mx), emx);
      check("hold_mz", int'(mz), emz);
    end
    out_ready = 1'b1;
    tick();
    check("out_drop", int'(out_valid), 0);
    out_ready = 1'b0;
    $display("point n=%0d x=%0d y=%0d z=%0d plus=%0d -> mx=%0d my=%0d mz=%0d err=%0d",
             nn, xx, yy, zz, pl, mx, my, mz, err_div);
  endtask

  // Probe the cursor: a zero point with n=1 lands exactly on (x_cur, y_cur).
  task automatic probe();
    send_point(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_adv(input int nn, input int jj);
    bit exp_acc, was_full, saw;
    exp_acc  = (jj == 0) && !m_full;
    was_full = m_full;
    saw      = 1'b0;
    n    = NW'(nn);
    just = jj[0];
    adv  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 3) adv = 1'b0;
      if (busy) saw = 1'b1;
    end
    if (exp_acc) model_adv(nn);
    check("adv_busy_seen", int'(saw), (exp_acc || was_full) ? 1 : 0);
    check("busy_after", int'(busy), int'(m_full));
    check("full", int'(full), int'(m_full));
    just = 1'b0;
    $display("adv n=%0d just=%0d -> xcur=%0d ycur=%0d full=%0d", nn, jj, m_xcur, m_ycur, full);
  endtask

  task automatic do_contin();
    contin = 1'b1;
    repeat (4) tick();
    contin = 1'b0;
    repeat (6) tick();
    m_full = 1'b0;
    check("contin_full", int'(full), 0);
    check("contin_busy", int'(busy), 0);
    $display("contin -> full=%0d busy=%0d", full, busy);
  endtask

  initial begin
    int k;
    // Reset state.
    #3;
    check("rst_pt_ready", int'(pt_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mx", int'(mx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_full", int'(full), 0);
    check("rst_err", int'(err_div), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    check("rel_pt_ready_before", int'(pt_ready), 0);
    tick();
    check("rel_pt_ready_after", int'(pt_ready), 1);

    // Basic scaling and depth modes.
    send_point(2, 600, 400, 150, 0, 0);
    send_point(2, 100, 50, 300, 0, 2);
    send_point(2, 100, 50, 300, 1, 0);

    // n=0 point, then a suppressed advance.
    send_point(0, 500, 300, 250, 0, 2);
    do_adv(3, 1);

    // Line stepping with n=4 (cell 250): seven steps, then a line wrap.
    for (int i = 0; i < 8; i++) begin
      do_adv(4, 0);
      probe();
    end

    // Reset in the middle of a divide.
    n = 4'd3; x = 10'd900; y = 10'd600; z = '0; plus = 1'b0;
    pt_valid = 1'b1;
    k = 0;
    while (!pt_ready && k < 100) begin
      tick();
      k++;
    end
    check("mid_pt_ready_wait", int'(pt_ready), 1);
    tick();
    pt_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_out_valid", int'(out_valid), 0);
    check("mid_my", int'(my), 0);
    check("mid_pt_ready", int'(pt_ready), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_full", int'(full), 0);
    check("mid_err", int'(err_div), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_pt_ready", int'(pt_ready), 1);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) k++;
    end
    check("mid_no_spurious", k, 0);

    // Full page with n=1, ignored advance, continue.
    do_adv(1, 0);
    probe();
    do_adv(1, 0);
    do_adv(1, 0);
    do_contin();
    probe();

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (m_full) do_contin();
      else if (r < 3) do_adv(int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 1 : 0);
      else send_point(int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/page_layout.md
PAGE_LAYOUT -- requirements
Module: page_layout

Interface
REQ-001 Parameters (name, default, meaning): CW, 10, local x/y/z coordinate width; PW, 11, page coordinate width; NW, 4, divisor width; X_EDGE, 2001, page x limit; Y_EDGE, 1501, page y limit; CELL_FULL, 1000, cell size at n=1; Z_THR, 200, pen-contact z threshold; Z_PLUS, 30, extra depth in plus mode.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 n  in  NW  characters per line (scale divisor); sampled only at a point accept or an advance start.
REQ-005 pt_valid / pt_ready  in / out  1 / 1  input point handshake; transfer when both high.
REQ-006 x, y, z  in  CW / CW / CW-1  character-local point.
REQ-007 plus  in  1  deep-stroke mode, sampled at point accept.
REQ-008 out_valid / out_ready  out / in  1 / 1  output point handshake.
REQ-009 mx, my, mz  out  PW / PW / CW-1  page-global point, stable while out_valid high.
REQ-010 adv, just, contin  in  1 each  asynchronous character-advance request, advance suppress, page-continue request.
REQ-011 full, busy, err_div  out  1 each  page full waiting for contin; cursor update in progress; last accepted point had n=0.

Function
REQ-012 adv and contin SHALL each pass a 2-flop synchroniser; only a 0->1 edge after synchronisation is an event.
REQ-013 Point FSM states P_IDLE, P_DIV, P_OUT; pt_ready SHALL be 1 only in P_IDLE with cursor FSM in C_IDLE.
REQ-014 On accept: latch x, y, n, and dz = (z>Z_THR) ? (plus ? z-Z_THR+Z_PLUS : z-Z_THR) : 0; enter P_DIV.
REQ-015 P_DIV SHALL run a shared-control restoring divider, one quotient bit per cycle, computing x/n, y/n, dz/n in parallel in exactly CW cycles, then enter P_OUT.
REQ-016 out_valid SHALL rise on the CW+1th rising edge after the accept edge; mx = x_cur+quo_x, my = y_cur+quo_y, mz = (dz>0) ? quo_z+Z_THR : z.
REQ-017 n=0 at accept: quotients 0, err_div=1 until next accept; otherwise err_div=0.
REQ-018 P_OUT held, outputs frozen, until out_ready=1; then P_IDLE on that edge.
REQ-019 Cursor FSM states C_IDLE, C_SIZE, C_MAX, C_STEP, C_WAIT; registers x_cur, y_cur, y_max (PW bits), size.
REQ-020 An adv event with just=0 SHALL set one pending flag; extra events while pending or cursor busy are dropped; just=1 drops the event.
REQ-021 C_IDLE->C_SIZE when pending=1 and point FSM in P_IDLE; pending cleared; busy=1 in every state except C_IDLE.
REQ-022 C_SIZE SHALL compute size = floor((CELL_FULL + floor(n/2)) / n) serially in PW cycles; n=0 gives size 0.
REQ-023 C_MAX: y_max <= max(y_max, size).
REQ-024 C_STEP, comparisons in PW+2 bits: if x_cur+2*size <= X_EDGE then x_cur += size; else if y_cur+2*size <= Y_EDGE then x_cur=0, y_cur += y_max, y_max=0; else x_cur=0, y_cur=0, y_max=0, full=1, next C_WAIT; non-full cases return to C_IDLE.
REQ-025 C_WAIT: contin event clears full, returns to C_IDLE; adv events in C_WAIT dropped.
REQ-026 x_cur/y_cur SHALL change only in C_STEP, never while out_valid=1.

Reset
REQ-027 rst_n=0 SHALL immediately force: both FSMs idle, pt_ready=0 during reset and 1 on first edge after release, out_valid=0, mx=my=mz=0, full=0, busy=0, err_div=0, x_cur=y_cur=y_max=size=0, pending=0, synchronisers 0.
REQ-028 Reset mid-divide or in C_WAIT SHALL discard the operation; no out_valid follows release.

Verification
REQ-029 n=2, x=600, y=400, z=150, out_ready=1 -> out_valid on 11th edge after accept; mx=300, my=200, mz=150.
REQ-030 n=2, z=300: plus=0 -> mz=250; plus=1 -> mz=265.
REQ-031 n=4, seven adv events -> x_cur 250,500,750,1000,1250,1500,1750; eighth -> x_cur=0, y_cur=250.
REQ-032 n=1, two adv events -> first x_cur=1000; second full=1, x_cur=y_cur=0; adv ignored; contin edge -> full=0.
REQ-033 n=0 point -> err_div=1, mx=x_cur, my=y_cur; adv with just=1 -> busy stays 0.
REQ-034 rst_n low at cycle 5 of P_DIV -> all outputs 0 immediately; pt_ready=1 after release; no spurious out_valid.
